// File: rtl/rvh_l1d_pkg.sv
// Shared types for the L1D atomic-memory-operation path: the AMO opcode
// set, the sequencer states, the ALU opcodes and a lane sign-extension helper.
package rvh_l1d_pkg;

   typedef enum logic [3:0] {
      AMO_SWAP = 4'd0,
      AMO_ADD  = 4'd1,
      AMO_XOR  = 4'd2,
      AMO_AND  = 4'd3,
      AMO_OR   = 4'd4,
      AMO_MIN  = 4'd5,
      AMO_MAX  = 4'd6,
      AMO_MINU = 4'd7,
      AMO_MAXU = 4'd8,
      AMO_LR   = 4'd9,
      AMO_SC   = 4'd10
   } amo_op_e;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_REQ  = 3'd1,
      RD_WAIT = 3'd2,
      EXEC    = 3'd3,
      WR_REQ  = 3'd4,
      RESP    = 3'd5
   } amo_state_e;

   typedef enum logic [2:0] {
      ALU_ADD  = 3'd0,
      ALU_XOR  = 3'd1,
      ALU_AND  = 3'd2,
      ALU_OR   = 3'd3,
      ALU_SLT  = 3'd4,
      ALU_SLTU = 3'd5
   } alu_op_e;

   // Sign-extend a 32-bit lane to a full doubleword.
   function automatic logic [63:0] sext32(input logic [31:0] v);
      return {{32{v[31]}}, v};
   endfunction

endpackage

// File: rtl/rvh_l1d_alu.sv
// Small combinational ALU used as the execute stage of the AMO sequencer.
// SLT/SLTU return 0/1 in bit 0; op_w_i only affects ADD (32-bit sum,
// sign-extended), the logic ops are full width.
module rvh_l1d_alu
   import rvh_l1d_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  alu_op_e          op_i,
   input  logic             op_w_i,
   input  logic [XLEN-1:0]  a_i,
   input  logic [XLEN-1:0]  b_i,
   output logic [XLEN-1:0]  res_o
);

   logic [XLEN-1:0] sum;

   assign sum = a_i + b_i;

   // Select the result for the requested operation.
   always_comb begin
      res_o = '0;
      unique case (op_i)
         ALU_ADD:  res_o = op_w_i ? {{(XLEN-32){sum[31]}}, sum[31:0]} : sum;
         ALU_XOR:  res_o = a_i ^ b_i;
         ALU_AND:  res_o = a_i & b_i;
         ALU_OR:   res_o = a_i | b_i;
         ALU_SLT:  res_o = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
         ALU_SLTU: res_o = {{(XLEN-1){1'b0}}, (a_i < b_i)};
         default:  res_o = '0;
      endcase
   end

endmodule

// File: rtl/rvh_l1d_amo_ctrl.sv
// AMO / LR / SC sequencer for the L1D. Reads the old doubleword, runs the
// ALU, writes the result back and returns the old value (or SC status).
// Holds the single LR/SC reservation at cache-line granularity.
//
// Handshakes: every *_valid/*_ready pair transfers on a rising clock edge
// where both are high; a valid, once raised, stays high with stable payload
// until that edge. rd_resp_valid_i is a one-cycle pulse without backpressure.
module rvh_l1d_amo_ctrl
   import rvh_l1d_pkg::*;
#(
   parameter int XLEN              = 64,
   parameter int PADDR_WIDTH       = 56,
   parameter int ROB_TAG_WIDTH     = 7,
   parameter int LINE_OFFSET_WIDTH = 6
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req_valid_i,
   output logic                     req_ready_o,
   input  amo_op_e                  req_op_i,
   input  logic                     req_word_i,
   input  logic [PADDR_WIDTH-1:0]   req_paddr_i,
   input  logic [XLEN-1:0]          req_data_i,
   input  logic [ROB_TAG_WIDTH-1:0] req_tag_i,
   output logic                     rd_req_valid_o,
   input  logic                     rd_req_ready_i,
   output logic [PADDR_WIDTH-1:0]   rd_req_paddr_o,
   input  logic                     rd_resp_valid_i,
   input  logic [XLEN-1:0]          rd_resp_data_i,
   output logic                     wr_req_valid_o,
   input  logic                     wr_req_ready_i,
   output logic [PADDR_WIDTH-1:0]   wr_req_paddr_o,
   output logic [XLEN-1:0]          wr_req_data_o,
   output logic [XLEN/8-1:0]        wr_req_mask_o,
   output logic                     resp_valid_o,
   input  logic                     resp_ready_i,
   output logic [XLEN-1:0]          resp_data_o,
   output logic [ROB_TAG_WIDTH-1:0] resp_tag_o,
   input  logic                     snoop_inv_valid_i,
   input  logic [PADDR_WIDTH-1:0]   snoop_inv_paddr_i,
   output logic                     busy_o,
   output amo_state_e               dbg_state_o
);

   localparam int LINE_W = PADDR_WIDTH - LINE_OFFSET_WIDTH;

   amo_state_e               state_q, state_d;
   amo_op_e                  op_q, op_d;
   logic                     word_q, word_d;
   logic [PADDR_WIDTH-1:0]   paddr_q, paddr_d;
   logic [XLEN-1:0]          data_q, data_d;
   logic [ROB_TAG_WIDTH-1:0] tag_q, tag_d;
   logic [XLEN-1:0]          old_q, old_d;
   logic [XLEN-1:0]          new_q, new_d;
   logic                     sc_fail_q, sc_fail_d;
   logic                     resv_valid_q, resv_valid_d;
   logic [LINE_W-1:0]        resv_line_q, resv_line_d;

   logic [LINE_W-1:0]        req_line;
   logic [LINE_W-1:0]        cur_line;
   logic [LINE_W-1:0]        snoop_line;
   logic                     sc_ok;

   alu_op_e                  alu_op;
   logic                     alu_w;
   logic [XLEN-1:0]          rs2_ext;
   logic [XLEN-1:0]          alu_res;
   logic                     alu_lt;
   logic [XLEN-1:0]          exec_val;

   assign req_line   = req_paddr_i[PADDR_WIDTH-1:LINE_OFFSET_WIDTH];
   assign cur_line   = paddr_q[PADDR_WIDTH-1:LINE_OFFSET_WIDTH];
   assign snoop_line = snoop_inv_paddr_i[PADDR_WIDTH-1:LINE_OFFSET_WIDTH];

   // SC succeeds only on a live reservation for the same line that is not
   // being snooped away in this very cycle.
   assign sc_ok = resv_valid_q && (resv_line_q == req_line) &&
                  !(snoop_inv_valid_i && (snoop_line == req_line));

   // Execute-stage operand and opcode selection; W operands are sign-extended
   // so 64-bit signed/unsigned compares order 32-bit values correctly.
   always_comb begin
      alu_op  = ALU_ADD;
      alu_w   = 1'b0;
      rs2_ext = word_q ? sext32(data_q[31:0]) : data_q;
      unique case (op_q)
         AMO_ADD:             begin alu_op = ALU_ADD; alu_w = word_q; end
         AMO_XOR:             alu_op = ALU_XOR;
         AMO_AND:             alu_op = ALU_AND;
         AMO_OR:              alu_op = ALU_OR;
         AMO_MIN, AMO_MAX:    alu_op = ALU_SLT;
         AMO_MINU, AMO_MAXU:  alu_op = ALU_SLTU;
         default:             alu_op = ALU_ADD;
      endcase
   end

   rvh_l1d_alu #(.XLEN(XLEN)) u_alu (
      .op_i   (alu_op),
      .op_w_i (alu_w),
      .a_i    (old_q),
      .b_i    (rs2_ext),
      .res_o  (alu_res)
   );

   assign alu_lt = alu_res[0];

   // New memory value: swap bypasses the ALU, min/max pick from the compare.
   always_comb begin
      exec_val = alu_res;
      unique case (op_q)
         AMO_SWAP:            exec_val = rs2_ext;
         AMO_MIN, AMO_MINU:   exec_val = alu_lt ? old_q : rs2_ext;
         AMO_MAX, AMO_MAXU:   exec_val = alu_lt ? rs2_ext : old_q;
         default:             exec_val = alu_res;
      endcase
   end

   // Next-state, request capture and reservation bookkeeping.
   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      word_d       = word_q;
      paddr_d      = paddr_q;
      data_d       = data_q;
      tag_d        = tag_q;
      old_d        = old_q;
      new_d        = new_q;
      sc_fail_d    = sc_fail_q;
      resv_valid_d = resv_valid_q;
      resv_line_d  = resv_line_q;

      // A probe of the reserved line always kills the reservation.
      if (snoop_inv_valid_i && (snoop_line == resv_line_q)) begin
         resv_valid_d = 1'b0;
      end

      unique case (state_q)
         IDLE: begin
            if (req_valid_i) begin
               op_d      = req_op_i;
               word_d    = req_word_i;
               paddr_d   = req_paddr_i;
               data_d    = req_data_i;
               tag_d     = req_tag_i;
               old_d     = '0;
               sc_fail_d = 1'b0;
               if (req_op_i == AMO_SC) begin
                  resv_valid_d = 1'b0;
                  sc_fail_d    = !sc_ok;
                  new_d        = req_data_i;
                  state_d      = sc_ok ? WR_REQ : RESP;
               end else begin
                  state_d = RD_REQ;
               end
            end
         end
         RD_REQ: begin
            if (rd_req_ready_i) state_d = RD_WAIT;
         end
         RD_WAIT: begin
            if (rd_resp_valid_i) begin
               if (word_q) begin
                  old_d = paddr_q[2] ? sext32(rd_resp_data_i[63:32])
                                     : sext32(rd_resp_data_i[31:0]);
               end else begin
                  old_d = rd_resp_data_i;
               end
               if (op_q == AMO_LR) begin
                  state_d = RESP;
                  // Snoop clear wins over the LR set in the same cycle.
                  if (!(snoop_inv_valid_i && (snoop_line == cur_line))) begin
                     resv_valid_d = 1'b1;
                     resv_line_d  = cur_line;
                  end
               end else begin
                  state_d = EXEC;
               end
            end
         end
         EXEC: begin
            new_d   = exec_val;
            state_d = WR_REQ;
         end
         WR_REQ: begin
            if (wr_req_ready_i) state_d = RESP;
         end
         RESP: begin
            if (resp_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers, cleared asynchronously.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         op_q         <= AMO_SWAP;
         word_q       <= 1'b0;
         paddr_q      <= '0;
         data_q       <= '0;
         tag_q        <= '0;
         old_q        <= '0;
         new_q        <= '0;
         sc_fail_q    <= 1'b0;
         resv_valid_q <= 1'b0;
         resv_line_q  <= '0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         word_q       <= word_d;
         paddr_q      <= paddr_d;
         data_q       <= data_d;
         tag_q        <= tag_d;
         old_q        <= old_d;
         new_q        <= new_d;
         sc_fail_q    <= sc_fail_d;
         resv_valid_q <= resv_valid_d;
         resv_line_q  <= resv_line_d;
      end
   end

   // Interface outputs are decoded from the registered state only.
   assign req_ready_o    = (state_q == IDLE);
   assign busy_o         = (state_q != IDLE);
   assign dbg_state_o    = state_q;
   assign rd_req_valid_o = (state_q == RD_REQ);
   assign wr_req_valid_o = (state_q == WR_REQ);
   assign resp_valid_o   = (state_q == RESP);

   assign rd_req_paddr_o = {paddr_q[PADDR_WIDTH-1:3], 3'b000};
   assign wr_req_paddr_o = {paddr_q[PADDR_WIDTH-1:3], 3'b000};
   assign wr_req_data_o  = word_q ? {2{new_q[31:0]}} : new_q;
   assign wr_req_mask_o  = !word_q   ? 8'hFF :
                           paddr_q[2] ? 8'hF0 : 8'h0F;

   assign resp_data_o    = (op_q == AMO_SC) ? {{(XLEN-1){1'b0}}, sc_fail_q} : old_q;
   assign resp_tag_o     = tag_q;

`ifndef SYNTHESIS
   // Requests must be naturally aligned.
   a_aligned: assert property (@(posedge clk) disable iff (!rst)
      (req_valid_i && req_ready_o) |->
      (req_word_i ? (req_paddr_i[1:0] == 2'b00) : (req_paddr_i[2:0] == 3'b000)));

   // Read data is only expected while waiting for it.
   a_rd_resp: assert property (@(posedge clk) disable iff (!rst)
      rd_resp_valid_i |-> (state_q == RD_WAIT));
`endif

endmodule

// File: tb/tb_rvh_l1d_amo_ctrl.sv
// Directed bench for the L1D AMO sequencer.
module tb_rvh_l1d_amo_ctrl;
   import rvh_l1d_pkg::*;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready_o;
   amo_op_e     req_op;
   logic        req_word;
   logic [55:0] req_paddr;
   logic [63:0] req_data;
   logic [6:0]  req_tag;
   logic        rd_req_valid_o;
   logic        rd_req_ready;
   logic [55:0] rd_req_paddr_o;
   logic        rd_resp_valid;
   logic [63:0] rd_resp_data;
   logic        wr_req_valid_o;
   logic        wr_req_ready;
   logic [55:0] wr_req_paddr_o;
   logic [63:0] wr_req_data_o;
   logic [7:0]  wr_req_mask_o;
   logic        resp_valid_o;
   logic        resp_ready;
   logic [63:0] resp_data_o;
   logic [6:0]  resp_tag_o;
   logic        snoop_valid;
   logic [55:0] snoop_paddr;
   logic        busy_o;
   amo_state_e  dbg_state_o;

   int n_checks = 0;
   int n_fail   = 0;

   // Results of the most recent transaction.
   logic [63:0] r_resp;
   logic [6:0]  r_tag;
   logic        r_got_wr;
   logic [63:0] r_wdata;
   logic [7:0]  r_wmask;
   logic [55:0] r_wpaddr;
   logic [55:0] r_rpaddr;
   logic        r_unstable;
   int          r_rd_cyc, r_wr_cyc, r_resp_cyc, r_wr_hold;

   rvh_l1d_amo_ctrl dut (
      .clk               (clk),
      .rst               (rst),
      .req_valid_i       (req_valid),
      .req_ready_o       (req_ready_o),
      .req_op_i          (req_op),
      .req_word_i        (req_word),
      .req_paddr_i       (req_paddr),
      .req_data_i        (req_data),
      .req_tag_i         (req_tag),
      .rd_req_valid_o    (rd_req_valid_o),
      .rd_req_ready_i    (rd_req_ready),
      .rd_req_paddr_o    (rd_req_paddr_o),
      .rd_resp_valid_i   (rd_resp_valid),
      .rd_resp_data_i    (rd_resp_data),
      .wr_req_valid_o    (wr_req_valid_o),
      .wr_req_ready_i    (wr_req_ready),
      .wr_req_paddr_o    (wr_req_paddr_o),
      .wr_req_data_o     (wr_req_data_o),
      .wr_req_mask_o     (wr_req_mask_o),
      .resp_valid_o      (resp_valid_o),
      .resp_ready_i      (resp_ready),
      .resp_data_o       (resp_data_o),
      .resp_tag_o        (resp_tag_o),
      .snoop_inv_valid_i (snoop_valid),
      .snoop_inv_paddr_i (snoop_paddr),
      .busy_o            (busy_o),
      .dbg_state_o       (dbg_state_o)
   );

   // Clock and watchdog.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Issue one request at cycle 0, act as data array and LSU, record timing.
   task automatic do_req(input amo_op_e op, input logic word, input logic [55:0] pa,
                         input logic [63:0] rs2, input logic [6:0] tag,
                         input logic [63:0] mem, input int wr_stall);
      logic rd_pend;
      logic done;
      int   holds;
      r_got_wr   = 1'b0;
      r_unstable = 1'b0;
      r_rd_cyc   = -1;
      r_wr_cyc   = -1;
      r_resp_cyc = -1;
      r_resp     = '0;
      r_tag      = '0;
      r_rpaddr   = '0;
      holds      = 0;
      rd_pend    = 1'b0;
      done       = 1'b0;
      @(negedge clk);
      req_valid    = 1'b1;
      req_op       = op;
      req_word     = word;
      req_paddr    = pa;
      req_data     = rs2;
      req_tag      = tag;
      rd_req_ready = 1'b1;
      wr_req_ready = 1'b0;
      resp_ready   = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      for (int c = 1; c <= 40 && !done; c++) begin
         @(negedge clk);
         rd_resp_valid = 1'b0;
         if (rd_pend) begin
            rd_resp_valid = 1'b1;
            rd_resp_data  = mem;
            rd_pend       = 1'b0;
         end
         if (rd_req_valid_o && r_rd_cyc < 0) begin
            r_rd_cyc = c;
            r_rpaddr = rd_req_paddr_o;
            rd_pend  = 1'b1;
         end
         if (wr_req_valid_o) begin
            if (!r_got_wr) begin
               r_got_wr = 1'b1;
               r_wr_cyc = c;
               r_wdata  = wr_req_data_o;
               r_wmask  = wr_req_mask_o;
               r_wpaddr = wr_req_paddr_o;
            end else if (wr_req_data_o !== r_wdata || wr_req_mask_o !== r_wmask ||
                         wr_req_paddr_o !== r_wpaddr) begin
               r_unstable = 1'b1;
            end
            holds++;
            wr_req_ready = (holds > wr_stall);
         end else begin
            wr_req_ready = 1'b0;
         end
         if (resp_valid_o) begin
            r_resp_cyc = c;
            r_resp     = resp_data_o;
            r_tag      = resp_tag_o;
            done       = 1'b1;
         end
      end
      r_wr_hold = holds;
      @(posedge clk);
      #1;
      rd_resp_valid = 1'b0;
      wr_req_ready  = 1'b0;
      n_checks++;
      if (!done) begin
         n_fail++;
         $display("FAIL resp_timeout: no response within 40 cycles, got none want one");
      end
   endtask

   task automatic do_snoop(input logic [55:0] pa);
      @(negedge clk);
      snoop_valid = 1'b1;
      snoop_paddr = pa;
      @(negedge clk);
      snoop_valid = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_checks++; if (resp_valid_o !== 1'b0 || rd_req_valid_o !== 1'b0 || wr_req_valid_o !== 1'b0) begin
         n_fail++; $display("FAIL reset_valids: got rd=%b wr=%b resp=%b want 0 0 0", rd_req_valid_o, wr_req_valid_o, resp_valid_o); end
      n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_o); end
      n_checks++; if (dbg_state_o !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", dbg_state_o, IDLE); end
      rst = 1'b1;
      @(negedge clk);
      n_checks++; if (req_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", req_ready_o); end
      n_checks++; if (resp_data_o !== 64'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", resp_data_o); end
   endtask

   task automatic test_amoadd_d();
      do_req(AMO_ADD, 1'b0, 56'h1000, 64'h3, 7'h11, 64'h5, 0);
      n_checks++; if (r_rd_cyc !== 1) begin n_fail++; $display("FAIL add_rd_cycle: got %0d want 1", r_rd_cyc); end
      n_checks++; if (r_rpaddr !== 56'h1000) begin n_fail++; $display("FAIL add_rd_paddr: got %h want 1000", r_rpaddr); end
      n_checks++; if (r_wr_cyc !== 4) begin n_fail++; $display("FAIL add_wr_cycle: got %0d want 4", r_wr_cyc); end
      n_checks++; if (r_resp_cyc !== 5) begin n_fail++; $display("FAIL add_resp_cycle: got %0d want 5", r_resp_cyc); end
      n_checks++; if (r_resp !== 64'h5) begin n_fail++; $display("FAIL add_resp_data: got %h want 5", r_resp); end
      n_checks++; if (r_wdata !== 64'h8) begin n_fail++; $display("FAIL add_wr_data: got %h want 8", r_wdata); end
      n_checks++; if (r_wmask !== 8'hFF) begin n_fail++; $display("FAIL add_wr_mask: got %h want ff", r_wmask); end
      n_checks++; if (r_wpaddr !== 56'h1000) begin n_fail++; $display("FAIL add_wr_paddr: got %h want 1000", r_wpaddr); end
      n_checks++; if (r_tag !== 7'h11) begin n_fail++; $display("FAIL add_tag: got %h want 11", r_tag); end
   endtask

   task automatic test_amomin_w();
      do_req(AMO_MIN, 1'b1, 56'h1004, 64'h1, 7'h22, 64'hFFFF_FFFE_0000_0007, 0);
      n_checks++; if (r_resp !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_fail++; $display("FAIL minw_resp: got %h want fffffffffffffffe", r_resp); end
      n_checks++; if (r_wdata[63:32] !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL minw_lane: got %h want fffffffe", r_wdata[63:32]); end
      n_checks++; if (r_wmask !== 8'hF0) begin n_fail++; $display("FAIL minw_mask: got %h want f0", r_wmask); end
      n_checks++; if (r_wpaddr !== 56'h1000) begin n_fail++; $display("FAIL minw_paddr: got %h want 1000", r_wpaddr); end
   endtask

   task automatic test_amoadd_w_low();
      // Low lane, 32-bit overflow: 0x7fffffff + 1 wraps to 0x80000000.
      do_req(AMO_ADD, 1'b1, 56'h1000, 64'h1, 7'h05, 64'hAAAA_AAAA_7FFF_FFFF, 0);
      n_checks++; if (r_resp !== 64'h0000_0000_7FFF_FFFF) begin n_fail++; $display("FAIL addw_resp: got %h want 7fffffff", r_resp); end
      n_checks++; if (r_wdata !== 64'h8000_0000_8000_0000) begin n_fail++; $display("FAIL addw_data: got %h want 8000000080000000", r_wdata); end
      n_checks++; if (r_wmask !== 8'h0F) begin n_fail++; $display("FAIL addw_mask: got %h want 0f", r_wmask); end
   endtask

   task automatic test_wr_stall();
      do_req(AMO_MAXU, 1'b0, 56'h1010, 64'hFFFF_FFFF_FFFF_FFFF, 7'h33, 64'h1, 3);
      n_checks++; if (r_wr_hold !== 4) begin n_fail++; $display("FAIL stall_hold: got %0d want 4", r_wr_hold); end
      n_checks++; if (r_unstable !== 1'b0) begin n_fail++; $display("FAIL stall_stable: got %b want 0", r_unstable); end
      n_checks++; if (r_wdata !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL stall_data: got %h want ffffffffffffffff", r_wdata); end
      n_checks++; if (r_resp !== 64'h1) begin n_fail++; $display("FAIL stall_resp: got %h want 1", r_resp); end
      n_checks++; if (r_resp_cyc !== 8) begin n_fail++; $display("FAIL stall_resp_cycle: got %0d want 8", r_resp_cyc); end
   endtask

   task automatic test_lr_sc();
      do_req(AMO_LR, 1'b0, 56'h2000, 64'h0, 7'h40, 64'h1234, 0);
      n_checks++; if (r_resp !== 64'h1234) begin n_fail++; $display("FAIL lr_resp: got %h want 1234", r_resp); end
      n_checks++; if (r_got_wr !== 1'b0) begin n_fail++; $display("FAIL lr_no_write: got %b want 0", r_got_wr); end
      do_req(AMO_SC, 1'b0, 56'h2008, 64'hAB, 7'h41, 64'h0, 0);
      n_checks++; if (r_resp !== 64'h0) begin n_fail++; $display("FAIL sc1_resp: got %h want 0", r_resp); end
      n_checks++; if (r_got_wr !== 1'b1 || r_wdata !== 64'hAB) begin n_fail++; $display("FAIL sc1_write: got %b/%h want 1/ab", r_got_wr, r_wdata); end
      n_checks++; if (r_wpaddr !== 56'h2008) begin n_fail++; $display("FAIL sc1_paddr: got %h want 2008", r_wpaddr); end
      n_checks++; if (r_resp_cyc !== 2) begin n_fail++; $display("FAIL sc1_cycle: got %0d want 2", r_resp_cyc); end
      do_req(AMO_SC, 1'b0, 56'h2008, 64'hAB, 7'h42, 64'h0, 0);
      n_checks++; if (r_resp !== 64'h1) begin n_fail++; $display("FAIL sc2_resp: got %h want 1", r_resp); end
      n_checks++; if (r_got_wr !== 1'b0) begin n_fail++; $display("FAIL sc2_no_write: got %b want 0", r_got_wr); end
      n_checks++; if (r_resp_cyc !== 1) begin n_fail++; $display("FAIL sc2_cycle: got %0d want 1", r_resp_cyc); end
   endtask

   task automatic test_snoop();
      do_req(AMO_LR, 1'b0, 56'h2000, 64'h0, 7'h50, 64'h77, 0);
      do_snoop(56'h2030);
      do_req(AMO_SC, 1'b0, 56'h2000, 64'h99, 7'h51, 64'h0, 0);
      n_checks++; if (r_resp !== 64'h1) begin n_fail++; $display("FAIL snoop_sc_resp: got %h want 1", r_resp); end
      n_checks++; if (r_got_wr !== 1'b0) begin n_fail++; $display("FAIL snoop_sc_write: got %b want 0", r_got_wr); end
   endtask

   task automatic test_reset_mid();
      do_req(AMO_LR, 1'b0, 56'h3000, 64'h0, 7'h60, 64'h5, 0);
      @(negedge clk);
      req_valid = 1'b1; req_op = AMO_ADD; req_word = 1'b0;
      req_paddr = 56'h3000; req_data = 64'h1; req_tag = 7'h61;
      rd_req_ready = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n_checks++; if (dbg_state_o !== RD_WAIT) begin n_fail++; $display("FAIL mid_state: got %0d want %0d", dbg_state_o, RD_WAIT); end
      rst = 1'b0;
      #1;
      n_checks++; if (rd_req_valid_o !== 1'b0 || wr_req_valid_o !== 1'b0 || resp_valid_o !== 1'b0) begin
         n_fail++; $display("FAIL mid_valids: got %b%b%b want 000", rd_req_valid_o, wr_req_valid_o, resp_valid_o); end
      n_checks++; if (dbg_state_o !== IDLE || busy_o !== 1'b0) begin n_fail++; $display("FAIL mid_idle: got state %0d busy %b want 0 0", dbg_state_o, busy_o); end
      @(negedge clk);
      rst = 1'b1;
      do_req(AMO_SC, 1'b0, 56'h3000, 64'h4, 7'h62, 64'h0, 0);
      n_checks++; if (r_resp !== 64'h1 || r_got_wr !== 1'b0) begin n_fail++; $display("FAIL mid_sc: got %h/%b want 1/0", r_resp, r_got_wr); end
   endtask

   initial begin
      rst           = 1'b0;
      req_valid     = 1'b0;
      req_op        = AMO_SWAP;
      req_word      = 1'b0;
      req_paddr     = '0;
      req_data      = '0;
      req_tag       = '0;
      rd_req_ready  = 1'b0;
      rd_resp_valid = 1'b0;
      rd_resp_data  = '0;
      wr_req_ready  = 1'b0;
      resp_ready    = 1'b0;
      snoop_valid   = 1'b0;
      snoop_paddr   = '0;
      repeat (3) @(posedge clk);
      test_reset();
      test_amoadd_d();
      test_amomin_w();
      test_amoadd_w_low();
      test_wr_stall();
      test_lr_sc();
      test_snoop();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
